// File: rtl/cmd_pkg.sv
// Shared command definitions: opcode map, field widths and dispatcher state encoding.
package cmd_pkg;

  localparam int unsigned OPC_W  = 8;
  localparam int unsigned SLOT_W = 4;
  localparam int unsigned ADDR_W = 48;
  localparam int unsigned CNT_W  = 16;

  localparam logic [OPC_W-1:0] OP_HALT  = 8'h00;
  localparam logic [OPC_W-1:0] OP_LOAD  = 8'h01;
  localparam logic [OPC_W-1:0] OP_STORE = 8'h02;
  localparam logic [OPC_W-1:0] OP_NTT   = 8'h10;
  localparam logic [OPC_W-1:0] OP_INTT  = 8'h11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DMA_REQ  = 3'd1,
    S_DMA_WAIT = 3'd2,
    S_OP_START = 3'd3,
    S_OP_WAIT  = 3'd4,
    S_RETIRE   = 3'd5
  } state_e;

endpackage

// File: rtl/cmd_decode.sv
// Combinational opcode/slot classifier; also usable by the command processor for pre-checks.
module cmd_decode
  import cmd_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 8
) (
  input  logic [OPC_W-1:0]  i_opcode,
  input  logic [SLOT_W-1:0] i_slot,
  output logic              o_is_dma_c,
  output logic              o_is_write_c,
  output logic              o_is_op_c,
  output logic              o_is_inverse_c,
  output logic              o_illegal_c
);

  logic w_slot_bad;

  // Widen by one bit so NUM_SLOTS = 2**SLOT_W still compares correctly.
  assign w_slot_bad = ({1'b0, i_slot} >= (SLOT_W + 1)'(NUM_SLOTS));

  always_comb begin
    o_is_dma_c     = 1'b0;
    o_is_write_c   = 1'b0;
    o_is_op_c      = 1'b0;
    o_is_inverse_c = 1'b0;
    case (i_opcode)
      OP_LOAD:  o_is_dma_c = 1'b1;
      OP_STORE: begin
        o_is_dma_c   = 1'b1;
        o_is_write_c = 1'b1;
      end
      OP_NTT:   o_is_op_c = 1'b1;
      OP_INTT:  begin
        o_is_op_c      = 1'b1;
        o_is_inverse_c = 1'b1;
      end
      default:  ;
    endcase
    o_illegal_c = !(o_is_dma_c || o_is_op_c) || w_slot_bad;
  end

endmodule

// File: rtl/engine_cmd_dispatcher.sv
// Engine-side command responder: captures strobed commands and dispatches to DMA or transform core.
// Optional watchdog (err_timeout port, TIMEOUT_CYCLES parameter) enabled by CMD_WATCHDOG_EN.
module engine_cmd_dispatcher
  import cmd_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 8
`ifdef CMD_WATCHDOG_EN
  , parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [OPC_W-1:0]  cmd_opcode,
  input  logic [SLOT_W-1:0] cmd_slot,
  input  logic [ADDR_W-1:0] cmd_dma_addr,
  output logic              engine_ready,
  output logic              dma_req_valid,
  input  logic              dma_req_ready,
  output logic              dma_req_write,
  output logic [ADDR_W-1:0] dma_req_addr,
  output logic [SLOT_W-1:0] dma_req_slot,
  input  logic              dma_done,
  output logic              op_start,
  output logic              op_inverse,
  output logic [SLOT_W-1:0] op_slot,
  input  logic              op_done,
  output logic              err_illegal,
  output logic              err_dropped,
`ifdef CMD_WATCHDOG_EN
  output logic              err_timeout,
`endif
  output logic [CNT_W-1:0]  retired_count
);

  state_e            r_state, w_next;
  logic              w_is_dma, w_is_write, w_is_op, w_is_inverse, w_illegal;
  logic              w_capture, w_timeout;
  logic              r_engine_ready, r_dma_req_valid, r_op_start;
  logic              r_write, r_inverse, r_err_illegal, r_err_dropped;
  logic [ADDR_W-1:0] r_addr;
  logic [SLOT_W-1:0] r_slot;
  logic [CNT_W-1:0]  r_retired;

  cmd_decode #(.NUM_SLOTS(NUM_SLOTS)) u_decode (
    .i_opcode       (cmd_opcode),
    .i_slot         (cmd_slot),
    .o_is_dma_c     (w_is_dma),
    .o_is_write_c   (w_is_write),
    .o_is_op_c      (w_is_op),
    .o_is_inverse_c (w_is_inverse),
    .o_illegal_c    (w_illegal)
  );

  assign w_capture = (r_state == S_IDLE) && cmd_valid;

`ifdef CMD_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_err_timeout;
  logic            w_wd_active;

  assign w_wd_active = (r_state == S_DMA_REQ) || (r_state == S_DMA_WAIT) ||
                       (r_state == S_OP_WAIT);
  assign w_timeout   = w_wd_active && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Counter restarts on every state change, so each waiting state gets a full budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt      <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_next != r_state) r_wd_cnt <= '0;
      else if (w_wd_active)  r_wd_cnt <= r_wd_cnt + WD_W'(1);
      if (w_timeout) r_err_timeout <= 1'b1;
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (cmd_valid && !w_illegal) w_next = w_is_dma ? S_DMA_REQ : S_OP_START;
      S_DMA_REQ:  if (dma_req_ready) w_next = S_DMA_WAIT;
      S_DMA_WAIT: if (dma_done) w_next = S_RETIRE;
      S_OP_START: w_next = S_OP_WAIT;
      S_OP_WAIT:  if (op_done) w_next = S_RETIRE;
      S_RETIRE:   w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_IDLE;
  end

  // Handshake outputs are registered images of the next state, so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_engine_ready  <= 1'b1;
      r_dma_req_valid <= 1'b0;
      r_op_start      <= 1'b0;
      r_write         <= 1'b0;
      r_inverse       <= 1'b0;
      r_addr          <= '0;
      r_slot          <= '0;
      r_err_illegal   <= 1'b0;
      r_err_dropped   <= 1'b0;
      r_retired       <= '0;
    end else begin
      r_engine_ready  <= (w_next == S_IDLE);
      r_dma_req_valid <= (w_next == S_DMA_REQ);
      r_op_start      <= (w_next == S_OP_START);
      if (w_capture) begin
        r_write   <= w_is_write;
        r_inverse <= w_is_inverse;
        r_addr    <= cmd_dma_addr;
        r_slot    <= cmd_slot;
        if (w_illegal) r_err_illegal <= 1'b1;
      end
      if (cmd_valid && (r_state != S_IDLE)) r_err_dropped <= 1'b1;
      if (r_state == S_RETIRE) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign engine_ready  = r_engine_ready;
  assign dma_req_valid = r_dma_req_valid;
  assign dma_req_write = r_write;
  assign dma_req_addr  = r_addr;
  assign dma_req_slot  = r_slot;
  assign op_start      = r_op_start;
  assign op_inverse    = r_inverse;
  assign op_slot       = r_slot;
  assign err_illegal   = r_err_illegal;
  assign err_dropped   = r_err_dropped;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_engine_cmd_dispatcher.sv
// Directed scoreboard bench for engine_cmd_dispatcher; watchdog scenario built when CMD_WATCHDOG_EN is defined.
module tb_engine_cmd_dispatcher;

  typedef struct packed {
    logic        is_op;
    logic        flag;
    logic [47:0] addr;
    logic [3:0]  slot;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [3:0]  cmd_slot;
  logic [47:0] cmd_dma_addr;
  logic        engine_ready, dma_req_valid, dma_req_ready, dma_req_write;
  logic [47:0] dma_req_addr;
  logic [3:0]  dma_req_slot, op_slot;
  logic        dma_done, op_start, op_inverse, op_done;
  logic        err_illegal, err_dropped;
  logic [15:0] retired_count;
`ifdef CMD_WATCHDOG_EN
  logic        err_timeout;
`endif

  int   checks = 0;
  int   failures = 0;
  int   n_op_start = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

`ifdef CMD_WATCHDOG_EN
  engine_cmd_dispatcher #(.NUM_SLOTS(8), .TIMEOUT_CYCLES(16)) dut (
`else
  engine_cmd_dispatcher #(.NUM_SLOTS(8)) dut (
`endif
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode),
    .cmd_slot(cmd_slot), .cmd_dma_addr(cmd_dma_addr), .engine_ready(engine_ready),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
    .dma_req_write(dma_req_write), .dma_req_addr(dma_req_addr),
    .dma_req_slot(dma_req_slot), .dma_done(dma_done), .op_start(op_start),
    .op_inverse(op_inverse), .op_slot(op_slot), .op_done(op_done),
    .err_illegal(err_illegal), .err_dropped(err_dropped),
`ifdef CMD_WATCHDOG_EN
    .err_timeout(err_timeout),
`endif
    .retired_count(retired_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] opc, input logic [3:0] slot, input logic [47:0] addr);
    cmd_valid    = 1'b1;
    cmd_opcode   = opc;
    cmd_slot     = slot;
    cmd_dma_addr = addr;
    tick();
    cmd_valid    = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (engine_ready) break;
      tick();
    end
    chk("ready_wait", 64'(engine_ready), 64'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(engine_ready), 64'd1);
    chk({tag, "_dvalid"}, 64'(dma_req_valid), 64'd0);
    chk({tag, "_opstart"}, 64'(op_start), 64'd0);
    chk({tag, "_addr"}, 64'(dma_req_addr), 64'd0);
    chk({tag, "_slot"}, 64'({dma_req_slot, op_slot}), 64'd0);
    chk({tag, "_errs"}, 64'({err_illegal, err_dropped}), 64'd0);
    chk({tag, "_count"}, 64'(retired_count), 64'd0);
  endtask

  // Observe dispatches mid-cycle and pop the matching expectation.
  always @(negedge clk) begin
    if (!rst && (dma_req_valid && dma_req_ready || op_start)) begin
      exp_t got, want;
      if (op_start) begin
        n_op_start++;
        got = '{is_op: 1'b1, flag: op_inverse, addr: 48'd0, slot: op_slot};
      end else begin
        got = '{is_op: 1'b0, flag: dma_req_write, addr: dma_req_addr, slot: dma_req_slot};
      end
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_dispatch", 64'(got), 64'd0);
      end else begin
        want = sb_q.pop_front();
        chk("sb_dispatch", 64'(got), 64'(want));
      end
    end
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_slot = '0; cmd_dma_addr = '0;
    dma_req_ready = 1'b0; dma_done = 1'b0; op_done = 1'b0;
    tick(); tick();
    chk_reset_vals("rst0");
    rst = 1'b0;
    tick();

    // LOAD slot 3, DMA ready early, done five cycles after acceptance
    dma_req_ready = 1'b1;
    sb_q.push_back('{is_op: 1'b0, flag: 1'b0, addr: 48'h0000_1234_5678, slot: 4'd3});
    send(8'h01, 4'd3, 48'h0000_1234_5678);
    chk("ld_ready_low", 64'(engine_ready), 64'd0);
    chk("ld_valid", 64'(dma_req_valid), 64'd1);
    chk("ld_write", 64'(dma_req_write), 64'd0);
    tick();
    chk("ld_valid_drop", 64'(dma_req_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("ld_ready_wait", 64'(engine_ready), 64'd0);
      tick();
    end
    dma_done = 1'b1; tick(); dma_done = 1'b0;
    chk("ld_ready_retire", 64'(engine_ready), 64'd0);
    tick();
    chk("ld_ready_back", 64'(engine_ready), 64'd1);
    chk("ld_count", 64'(retired_count), 64'd1);

    // STORE slot 7 with a 10-cycle stall on the request channel
    dma_req_ready = 1'b0;
    sb_q.push_back('{is_op: 1'b0, flag: 1'b1, addr: 48'hABCD_0000_F00D, slot: 4'd7});
    send(8'h02, 4'd7, 48'hABCD_0000_F00D);
    for (int i = 0; i < 10; i++) begin
      chk("st_valid_hold", 64'(dma_req_valid), 64'd1);
      chk("st_addr_hold", 64'(dma_req_addr), 64'hABCD_0000_F00D);
      chk("st_write_hold", 64'({dma_req_write, dma_req_slot}), 64'h17);
      if (i < 9) tick();
    end
    dma_req_ready = 1'b1; tick(); dma_req_ready = 1'b0;
    chk("st_valid_drop", 64'(dma_req_valid), 64'd0);
    dma_done = 1'b1; tick(); dma_done = 1'b0;
    wait_ready(5);
    chk("st_count", 64'(retired_count), 64'd2);

    // NTT then INTT back-to-back, each completing as early as possible
    sb_q.push_back('{is_op: 1'b1, flag: 1'b0, addr: 48'd0, slot: 4'd2});
    sb_q.push_back('{is_op: 1'b1, flag: 1'b1, addr: 48'd0, slot: 4'd2});
    for (int k = 0; k < 2; k++) begin
      send((k == 0) ? 8'h10 : 8'h11, 4'd2, 48'd0);
      chk("op_start_hi", 64'(op_start), 64'd1);
      tick();
      chk("op_start_lo", 64'(op_start), 64'd0);
      op_done = 1'b1; tick(); op_done = 1'b0;
      chk("op_ready_retire", 64'(engine_ready), 64'd0);
      tick();
      chk("op_ready_back", 64'(engine_ready), 64'd1);
    end
    chk("op_start_cycles", 64'(n_op_start), 64'd2);
    chk("op_count", 64'(retired_count), 64'd4);

    // Illegal opcodes and slots: sticky error, no dispatch, no retire
    dma_req_ready = 1'b1;
    send(8'h55, 4'd1, 48'd0);
    chk("ill_opc_ready", 64'(engine_ready), 64'd1);
    chk("ill_opc_err", 64'(err_illegal), 64'd1);
    send(8'h01, 4'd9, 48'h1);
    chk("ill_slot_ready", 64'(engine_ready), 64'd1);
    send(8'h00, 4'd0, 48'h2);
    tick(); tick();
    chk("ill_ready_after", 64'(engine_ready), 64'd1);
    chk("ill_no_valid", 64'({dma_req_valid, op_start}), 64'd0);
    chk("ill_count", 64'(retired_count), 64'd4);
    dma_req_ready = 1'b0;

    // Command dropped during OP_WAIT; stray dma_done ignored there
    sb_q.push_back('{is_op: 1'b1, flag: 1'b0, addr: 48'd0, slot: 4'd5});
    send(8'h10, 4'd5, 48'd0);
    tick();
    dma_done = 1'b1;
    send(8'h01, 4'd1, 48'h99);
    dma_done = 1'b0;
    chk("drop_err", 64'(err_dropped), 64'd1);
    tick(); tick();
    chk("drop_still_busy", 64'(engine_ready), 64'd0);
    op_done = 1'b1; tick(); op_done = 1'b0;
    wait_ready(5);
    chk("drop_count", 64'(retired_count), 64'd5);
    chk("drop_no_dma", 64'(dma_req_valid), 64'd0);
    chk("ill_sticky", 64'(err_illegal), 64'd1);

    // Asynchronous reset while a DMA request is pending (abandoned, no expectation)
    send(8'h01, 4'd4, 48'h4444);
    chk("rst_pre_valid", 64'(dma_req_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    tick();
    rst = 1'b0;
    tick();

`ifdef CMD_WATCHDOG_EN
    sb_q.push_back('{is_op: 1'b1, flag: 1'b0, addr: 48'd0, slot: 4'd1});
    send(8'h10, 4'd1, 48'd0);
    wait_ready(40);
    chk("wd_timeout", 64'(err_timeout), 64'd1);
    chk("wd_count", 64'(retired_count), 64'd0);
`endif

    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
